bm_upd_sched: RTL and testbench

BM_UPD_SCHED -- requirements
Module: bm_upd_sched

---
 rtl/bm_upd_sched_if.sv | 32 +++
 rtl/bm_upd_sched.sv | 188 ++++++++++++++++++
 tb/tb_bm_upd_sched.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bm_upd_sched_if.sv
// Handshake/bus bundle between the line-pass requester, DET stage, update
// datapath and the bm_upd_sched scheduler.
interface bm_upd_sched_if #(
  parameter int LW_BITS = 10
);
  logic               start;
  logic [LW_BITS-1:0] line_width;
  logic [3:0]         num_phase;
  logic               det_rdy;
  logic               vout;
  logic               det_ack;
  logic [3:0]         dphase;
  logic               mode;
  logic               vin_m1;
  logic               wbank;
  logic               rbank;
  logic               busy;
  logic               done;
  logic               err;

  // Requester / environment side
  modport master (
    output start, line_width, num_phase, det_rdy, vout,
    input  det_ack, dphase, mode, vin_m1, wbank, rbank, busy, done, err
  );

  // Scheduler side
  modport slave (
    input  start, line_width, num_phase, det_rdy, vout,
    output det_ack, dphase, mode, vin_m1, wbank, rbank, busy, done, err
  );
endinterface

// File: rtl/bm_upd_sched.sv
// Multi-phase line-pass scheduler for the block-matching update datapath.
// One start runs num_phase passes; each pass waits for DET data, bursts
// vin_m1 for line_width cycles, then drains until the datapath has returned
// line_width vout strobes or a timeout expires. All outputs are registered.
module bm_upd_sched #(
  parameter int LW_BITS   = 10,
  parameter int DRAIN_TMO = 8
) (
  input  logic          clk,
  input  logic          rst,
  bm_upd_sched_if.slave bus
);

  localparam int DW = $clog2(DRAIN_TMO + 3);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TMO + 2);
  localparam logic [LW_BITS-1:0] VCNT_MAX = {LW_BITS{1'b1}};

  typedef enum logic [1:0] {IDLE, WAIT, RUN, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [LW_BITS-1:0] lw_q, lw_d;
  logic [LW_BITS-1:0] pix_q, pix_d;
  logic [LW_BITS-1:0] vcnt_q, vcnt_d;
  logic [3:0]         np_q, np_d;
  logic [3:0]         phase_q, phase_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;
  logic               det_ack_q, det_ack_d;
  logic [3:0]         dphase_q, dphase_d;
  logic               mode_q, mode_d;
  logic               vin_q, vin_d;
  logic               wbank_q, wbank_d;
  logic               rbank_q, rbank_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               start_acc;
  logic [3:0]         np_clamped;
  logic [LW_BITS-1:0] vcnt_next;
  logic               drain_ok;
  logic               final_phase;

  // Clamp the requested phase count into 1..8 and count returned vout strobes
  always_comb begin
    np_clamped = bus.num_phase;
    if (bus.num_phase == 4'd0) begin
      np_clamped = 4'd1;
    end else if (bus.num_phase > 4'd8) begin
      np_clamped = 4'd8;
    end
    vcnt_next = vcnt_q;
    if ((state_q == RUN || state_q == DRAIN) && bus.vout && vcnt_q != VCNT_MAX) begin
      vcnt_next = vcnt_q + LW_BITS'(1);
    end
    // The done cycle still counts as busy, so a start there is refused
    start_acc   = bus.start && (state_q == IDLE) && !done_q;
    drain_ok    = (vcnt_next >= lw_q);
    final_phase = (phase_q == np_q - 4'd1);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    lw_d      = lw_q;
    pix_d     = pix_q;
    vcnt_d    = vcnt_next;
    np_d      = np_q;
    phase_d   = phase_q;
    dcnt_d    = dcnt_q;
    det_ack_d = 1'b0;
    vin_d     = 1'b0;
    done_d    = 1'b0;
    wbank_d   = wbank_q;
    err_d     = err_q;

    if (bus.start && !start_acc) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start_acc) begin
          lw_d    = bus.line_width;
          np_d    = np_clamped;
          phase_d = 4'd0;
          wbank_d = 1'b0;
          if (bus.line_width == '0) begin
            // Empty line: report completion without running any pass
            done_d = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.det_rdy) begin
          state_d   = RUN;
          det_ack_d = 1'b1;
          vin_d     = 1'b1;
          pix_d     = LW_BITS'(1);
          vcnt_d    = '0;
        end
      end
      RUN: begin
        if (pix_q == lw_q) begin
          state_d = DRAIN;
          dcnt_d  = DW'(1);
        end else begin
          vin_d = 1'b1;
          pix_d = pix_q + LW_BITS'(1);
        end
      end
      DRAIN: begin
        if (drain_ok || dcnt_q == DRAIN_LAST) begin
          if (!drain_ok) begin
            err_d = 1'b1;
          end
          if (final_phase) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT;
            phase_d = phase_q + 4'd1;
            wbank_d = ~wbank_q;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    dphase_d = phase_d;
    mode_d   = (phase_d != 4'd0);
    rbank_d  = ~wbank_d;
    busy_d   = (state_d != IDLE) || done_d;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lw_q      <= '0;
      pix_q     <= '0;
      vcnt_q    <= '0;
      np_q      <= 4'd0;
      phase_q   <= 4'd0;
      dcnt_q    <= '0;
      det_ack_q <= 1'b0;
      dphase_q  <= 4'd0;
      mode_q    <= 1'b0;
      vin_q     <= 1'b0;
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lw_q      <= lw_d;
      pix_q     <= pix_d;
      vcnt_q    <= vcnt_d;
      np_q      <= np_d;
      phase_q   <= phase_d;
      dcnt_q    <= dcnt_d;
      det_ack_q <= det_ack_d;
      dphase_q  <= dphase_d;
      mode_q    <= mode_d;
      vin_q     <= vin_d;
      wbank_q   <= wbank_d;
      rbank_q   <= rbank_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.det_ack = det_ack_q;
  assign bus.dphase  = dphase_q;
  assign bus.mode    = mode_q;
  assign bus.vin_m1  = vin_q;
  assign bus.wbank   = wbank_q;
  assign bus.rbank   = rbank_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_bm_upd_sched.sv
// Testbench for bm_upd_sched: a procedural timeline model predicts every
// output each cycle; directed scenarios add literal expectations.
module tb_bm_upd_sched;
  localparam int LW  = 10;
  localparam int TMO = 8;
  localparam int VMAX = (1 << LW) - 1;

  logic clk;
  logic rst;
  bm_upd_sched_if #(.LW_BITS(LW)) bus ();

  bm_upd_sched #(.LW_BITS(LW), .DRAIN_TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       e_det_ack = 0, e_mode = 0, e_vin = 0, e_wbank = 0, e_rbank = 1;
  logic       e_busy = 0, e_done = 0, e_err = 0;
  logic [3:0] e_dphase = 0;
  bit         chk_en = 0;
  bit         m_rst;
  bit         s_start, s_det, s_vout, s_rst;
  int         s_lw, s_np;
  int         vc;

  task automatic mstep(input bit acc, input bit cnt);
    @(posedge clk);
    s_start = (bus.start === 1'b1);
    s_det   = (bus.det_rdy === 1'b1);
    s_vout  = (bus.vout === 1'b1);
    s_rst   = (rst === 1'b1);
    s_lw    = int'(bus.line_width);
    s_np    = int'(bus.num_phase);
    e_det_ack = 0;
    e_done    = 0;
    e_vin     = 0;
    if (s_rst) begin
      m_rst = 1;
      chk_en = 1;
      vc = 0;
      e_dphase = 0; e_mode = 0; e_wbank = 0; e_rbank = 1;
      e_busy = 0; e_err = 0;
    end else begin
      m_rst = 0;
      if (s_start && !acc) e_err = 1;
      if (cnt && s_vout && vc < VMAX) vc++;
    end
  endtask

  initial begin : model
    bit idle_acc;
    bit ab;
    int m_lw, m_np, dr;
    idle_acc = 1;
    forever begin
      mstep(idle_acc, 0);
      if (m_rst) begin idle_acc = 1; continue; end
      if (!(s_start && idle_acc)) begin e_busy = 0; idle_acc = 1; continue; end
      m_lw = s_lw;
      m_np = (s_np == 0) ? 1 : ((s_np > 8) ? 8 : s_np);
      e_dphase = 0; e_mode = 0; e_wbank = 0; e_rbank = 1;
      if (m_lw == 0) begin e_done = 1; e_busy = 1; idle_acc = 0; continue; end
      e_busy = 1;
      ab = 0;
      for (int p = 0; p < m_np; p++) begin
        e_dphase = 4'(p);
        e_mode   = (p != 0);
        do begin
          mstep(0, 0);
          if (m_rst) ab = 1;
        end while (!ab && !s_det);
        if (ab) break;
        e_det_ack = 1; e_vin = 1; vc = 0;
        for (int i = 1; i < m_lw; i++) begin
          mstep(0, 1);
          if (m_rst) begin ab = 1; break; end
          e_vin = 1;
        end
        if (ab) break;
        mstep(0, 1);
        if (m_rst) begin ab = 1; break; end
        dr = 1;
        forever begin
          mstep(0, 1);
          if (m_rst) begin ab = 1; break; end
          if (vc >= m_lw) break;
          if (dr == TMO + 2) begin e_err = 1; break; end
          dr++;
        end
        if (ab) break;
        if (p == m_np - 1) begin
          e_done = 1; idle_acc = 0;
        end else begin
          e_wbank = ~e_wbank; e_rbank = ~e_wbank;
        end
      end
      if (ab) idle_acc = 1;
    end
  end

  // ---------------- compare + monitor ----------------
  int cyc_n = 0, n_ack = 0, n_vin = 0, n_done = 0;
  int last_vin = 0, ack_gap = 0, done_gap = 0, last_dph = 0;
  int ack_dph [16];
  int ack_mode[16];
  int ack_wb  [16];

  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("det_ack", int'(bus.det_ack), int'(e_det_ack));
        chk("dphase",  int'(bus.dphase),  int'(e_dphase));
        chk("mode",    int'(bus.mode),    int'(e_mode));
        chk("vin_m1",  int'(bus.vin_m1),  int'(e_vin));
        chk("wbank",   int'(bus.wbank),   int'(e_wbank));
        chk("rbank",   int'(bus.rbank),   int'(e_rbank));
        chk("busy",    int'(bus.busy),    int'(e_busy));
        chk("done",    int'(bus.done),    int'(e_done));
        chk("err",     int'(bus.err),     int'(e_err));
      end
      cyc_n++;
      if (bus.det_ack === 1'b1) begin
        if (n_ack < 16) begin
          ack_dph[n_ack]  = int'(bus.dphase);
          ack_mode[n_ack] = int'(bus.mode);
          ack_wb[n_ack]   = int'(bus.wbank);
        end
        ack_gap  = cyc_n - last_vin - 1;
        last_dph = int'(bus.dphase);
        n_ack++;
      end
      if (bus.done === 1'b1) begin
        done_gap = cyc_n - last_vin - 1;
        n_done++;
      end
      if (bus.vin_m1 === 1'b1) begin
        n_vin++;
        last_vin = cyc_n;
      end
    end
  end

  // ---------------- det_rdy / vout generators ----------------
  int dmode = 0;  // 0 high, 1 low, 2 random, 3 manual
  int vmode = 0;  // 0 vin delayed 2, 1 low, 2 mixed random, 3 high
  bit vh1 = 0, vh2 = 0;

  initial begin : gen
    bus.vout = 0;
    bus.det_rdy = 0;
    forever begin
      @(negedge clk);
      case (vmode)
        0: bus.vout = vh2;
        1: bus.vout = 1'b0;
        2: bus.vout = ($urandom_range(0, 2) == 0) ? 1'($urandom_range(0, 1)) : vh2;
        default: bus.vout = 1'b1;
      endcase
      vh2 = vh1;
      vh1 = (bus.vin_m1 === 1'b1);
      case (dmode)
        0: bus.det_rdy = 1'b1;
        1: bus.det_rdy = 1'b0;
        2: bus.det_rdy = ($urandom_range(0, 2) == 0);
        default: ;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1; cyc(); cyc(); rst = 0;
  endtask

  task automatic mon_clr();
    n_ack = 0; n_vin = 0; n_done = 0;
  endtask

  task automatic start_pulse(input int lw, input int np);
    bus.line_width = LW'(lw);
    bus.num_phase  = 4'(np);
    bus.start = 1; cyc(); bus.start = 0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int d0, k;
    d0 = n_done; k = 0;
    while (n_done == d0 && k < budget) begin cyc(); k++; end
    chk({nm, "_done_seen"}, int'(n_done != d0), 1);
  endtask

  task automatic wait_ack(input int target, input int budget, input string nm);
    int k;
    k = 0;
    while (n_ack < target && k < budget) begin cyc(); k++; end
    chk({nm, "_ack_seen"}, int'(n_ack >= target), 1);
  endtask

  initial begin : main
    rst = 1; bus.start = 0; bus.line_width = '0; bus.num_phase = 4'd0;
    cyc(); cyc(); cyc();
    chk("rst_busy",  int'(bus.busy), 0);
    chk("rst_rbank", int'(bus.rbank), 1);
    chk("rst_wbank", int'(bus.wbank), 0);
    chk("rst_err",   int'(bus.err), 0);
    chk("rst_vin",   int'(bus.vin_m1), 0);
    rst = 0;
    cyc();

    // Three-phase pass with vout = vin delayed 2
    mon_clr(); start_pulse(4, 3); wait_done(300, "t1"); repeat (4) cyc();
    chk("t1_vin", n_vin, 12); chk("t1_ack", n_ack, 3); chk("t1_done", n_done, 1);
    chk("t1_dph", ack_dph[0] * 100 + ack_dph[1] * 10 + ack_dph[2], 12);
    chk("t1_mode", ack_mode[0] * 100 + ack_mode[1] * 10 + ack_mode[2], 11);
    chk("t1_wb", ack_wb[0] * 100 + ack_wb[1] * 10 + ack_wb[2], 10);
    chk("t1_err", int'(bus.err), 0);
    $display("T1 three-phase pass: vin=%0d acks=%0d done=%0d", n_vin, n_ack, n_done);

    // Phase-count clamping
    mon_clr(); start_pulse(3, 0); wait_done(300, "t2a"); cyc();
    chk("t2a_ack", n_ack, 1); chk("t2a_dph", last_dph, 0);
    mon_clr(); start_pulse(2, 12); wait_done(2000, "t2b"); cyc();
    chk("t2b_ack", n_ack, 8); chk("t2b_dph", last_dph, 7);
    $display("T2 clamp: np=12 gave %0d passes, last dphase %0d", n_ack, last_dph);

    // det_rdy held low in WAIT
    dmode = 3; bus.det_rdy = 0;
    mon_clr(); start_pulse(3, 1); repeat (20) cyc();
    chk("t3_novin", n_vin, 0); chk("t3_busy", int'(bus.busy), 1);
    bus.det_rdy = 1; cyc();
    chk("t3_ack", int'(bus.det_ack), 1);
    dmode = 0; wait_done(300, "t3");
    $display("T3 det_rdy stall: det_ack after release=%0d", n_ack);

    // vout tied low: DRAIN times out every phase
    do_rst(); vmode = 1;
    mon_clr(); start_pulse(4, 2); wait_done(400, "t4"); cyc();
    chk("t4_gap", ack_gap, 11); chk("t4_dgap", done_gap, 10);
    chk("t4_err", int'(bus.err), 1); chk("t4_ack", n_ack, 2); chk("t4_done", n_done, 1);
    $display("T4 drain timeout: wait gap=%0d done gap=%0d err=%0d", ack_gap, done_gap, bus.err);

    // start during RUN of phase 1
    do_rst(); vmode = 0;
    mon_clr(); start_pulse(4, 3); wait_ack(2, 200, "t5");
    start_pulse(7, 7); wait_done(300, "t5"); repeat (4) cyc();
    chk("t5_err", int'(bus.err), 1); chk("t5_ack", n_ack, 3);
    chk("t5_done", n_done, 1); chk("t5_vin", n_vin, 12);
    $display("T5 start while busy: acks=%0d done=%0d err=%0d", n_ack, n_done, bus.err);

    // rst in second vin cycle of phase 1
    mon_clr(); start_pulse(4, 3); wait_ack(2, 200, "t6"); cyc();
    rst = 1; cyc();
    chk("t6_busy", int'(bus.busy), 0); chk("t6_vin", int'(bus.vin_m1), 0);
    chk("t6_dph", int'(bus.dphase), 0); chk("t6_mode", int'(bus.mode), 0);
    chk("t6_wb", int'(bus.wbank), 0); chk("t6_rb", int'(bus.rbank), 1);
    chk("t6_err", int'(bus.err), 0); chk("t6_ackq", int'(bus.det_ack), 0);
    rst = 0; repeat (5) cyc();
    chk("t6_nodone", n_done, 0);
    mon_clr(); start_pulse(2, 2); wait_done(300, "t6b"); cyc();
    chk("t6b_ack", n_ack, 2); chk("t6b_vin", n_vin, 4); chk("t6b_done", n_done, 1);
    $display("T6 mid-pass reset then rerun: acks=%0d vin=%0d", n_ack, n_vin);

    // Empty line, plus start coincident with its done pulse
    do_rst(); mon_clr(); start_pulse(0, 2);
    chk("t9_done", int'(bus.done), 1);
    start_pulse(5, 2); repeat (10) cyc();
    chk("t9_err", int'(bus.err), 1); chk("t9_vin", n_vin, 0);
    chk("t9_ack", n_ack, 0); chk("t9_ndone", n_done, 1); chk("t9_busy", int'(bus.busy), 0);
    $display("T9 empty line: done=%0d err=%0d", n_done, bus.err);

    // vout counter saturation on a full-width line
    do_rst(); vmode = 3;
    mon_clr(); start_pulse(VMAX, 1); wait_done(1300, "t7"); cyc();
    chk("t7_vin", n_vin, VMAX); chk("t7_err", int'(bus.err), 0); chk("t7_dgap", done_gap, 1);
    $display("T7 saturation: vin=%0d err=%0d", n_vin, bus.err);

    // Randomized traffic checked by the model
    vmode = 2; dmode = 2;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.start = ($urandom_range(0, 11) == 0);
      bus.line_width = ($urandom_range(0, 7) == 0) ? LW'($urandom_range(0, 20))
                                                  : LW'($urandom_range(0, 6));
      bus.num_phase = 4'($urandom_range(0, 15));
      cyc();
    end
    rst = 0; bus.start = 0; vmode = 0; dmode = 0;
    repeat (20) cyc();
    $display("T8 random traffic: %0d checks so far, %0d errors", n_chk, n_err);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
